// File: rtl/prog_counter_host_if.sv
// Command/response link between a command issuer and the counter host.
// master = command issuer, slave = prog_counter_host.
interface prog_counter_host_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/prog_counter_host.sv
// Command-driven sequencer for an 8-bit programmable counter that shares a
// bidirectional data bus with this host. LOAD drives the bus and strobes the
// counter load, RUN pulses the count enable for a given number of cycles, READ
// lets the counter drive the bus and samples it. Every command yields exactly
// one response. All outputs come straight from flops; bus ownership always has
// at least one idle cycle (neither side driving) between owners.
module prog_counter_host #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    prog_counter_host_if.slave link,
    output logic             ctr_en,
    output logic             ctr_load,
    output logic             ctr_oe,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_oe,
    input  logic [WIDTH-1:0] bus_in,
    input  logic [WIDTH-1:0] ctr_q
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_RUN  = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;

    typedef enum logic [3:0] {
        IDLE,
        LD_SETUP,
        LD_STROBE,
        LD_REL,
        RUN,
        SETTLE,
        RD_TA,
        RD_SAMPLE,
        RESP
    } state_t;

    state_t           state;
    // Remaining enable cycles after the current one while in RUN.
    logic [WIDTH-1:0] run_left;

    // Sequencer: one state register plus every output, all registered so the
    // counter and bus pins never see combinational glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            run_left       <= '0;
            ctr_en         <= 1'b0;
            ctr_load       <= 1'b0;
            ctr_oe         <= 1'b0;
            bus_oe         <= 1'b0;
            bus_out        <= '0;
            link.cmd_ready <= 1'b1;
            link.rsp_valid <= 1'b0;
            link.rsp_err   <= 1'b0;
            link.rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (link.cmd_valid && link.cmd_ready) begin
                        link.cmd_ready <= 1'b0;
                        case (link.cmd_op)
                            OP_LOAD: begin
                                // Host takes the bus first; load strobes next cycle.
                                state   <= LD_SETUP;
                                bus_oe  <= 1'b1;
                                bus_out <= link.cmd_data;
                            end
                            OP_RUN: begin
                                if (link.cmd_data == '0) begin
                                    state <= SETTLE;
                                end else begin
                                    state    <= RUN;
                                    ctr_en   <= 1'b1;
                                    run_left <= link.cmd_data - WIDTH'(1);
                                end
                            end
                            OP_READ: begin
                                // Bus is already released by the host in IDLE.
                                state  <= RD_TA;
                                ctr_oe <= 1'b1;
                            end
                            default: begin
                                // Reserved op: reject without touching the counter.
                                state          <= RESP;
                                link.rsp_valid <= 1'b1;
                                link.rsp_err   <= 1'b1;
                                link.rsp_data  <= '0;
                            end
                        endcase
                    end
                end

                LD_SETUP: begin
                    state    <= LD_STROBE;
                    ctr_load <= 1'b1;
                end

                LD_STROBE: begin
                    // Drop load and bus together so ctr_load never outlives bus_oe.
                    state    <= LD_REL;
                    ctr_load <= 1'b0;
                    bus_oe   <= 1'b0;
                    bus_out  <= '0;
                end

                LD_REL: begin
                    // Counter has taken the load value; report what it now holds.
                    state          <= RESP;
                    link.rsp_valid <= 1'b1;
                    link.rsp_err   <= 1'b0;
                    link.rsp_data  <= ctr_q;
                end

                RUN: begin
                    if (run_left == '0) begin
                        state  <= SETTLE;
                        ctr_en <= 1'b0;
                    end else begin
                        run_left <= run_left - WIDTH'(1);
                    end
                end

                SETTLE: begin
                    // Last increment landed on the previous edge; ctr_q is final.
                    state          <= RESP;
                    link.rsp_valid <= 1'b1;
                    link.rsp_err   <= 1'b0;
                    link.rsp_data  <= ctr_q;
                end

                RD_TA: begin
                    // Turnaround cycle: counter drive settles before sampling.
                    state <= RD_SAMPLE;
                end

                RD_SAMPLE: begin
                    state          <= RESP;
                    ctr_oe         <= 1'b0;
                    link.rsp_valid <= 1'b1;
                    link.rsp_err   <= 1'b0;
                    link.rsp_data  <= bus_in;
                end

                RESP: begin
                    // Response held stable until the consumer takes it.
                    if (link.rsp_ready) begin
                        state          <= IDLE;
                        link.rsp_valid <= 1'b0;
                        link.rsp_err   <= 1'b0;
                        link.cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state          <= IDLE;
                    ctr_en         <= 1'b0;
                    ctr_load       <= 1'b0;
                    ctr_oe         <= 1'b0;
                    bus_oe         <= 1'b0;
                    bus_out        <= '0;
                    link.cmd_ready <= 1'b1;
                    link.rsp_valid <= 1'b0;
                    link.rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_counter_host.sv
// Directed bench for prog_counter_host with a behavioural 8-bit counter on the
// shared bus and a per-cycle bus-ownership monitor.
module tb_prog_counter_host;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ctr_en, ctr_load, ctr_oe, bus_oe;
    logic [7:0] bus_out, bus_in, ctr_q;
    logic [7:0] model_q = 8'h00;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    logic prev_bus_oe = 1'b0;
    logic prev_ctr_oe = 1'b0;

    prog_counter_host_if #(.WIDTH(8)) link ();

    prog_counter_host #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .link     (link),
        .ctr_en   (ctr_en),
        .ctr_load (ctr_load),
        .ctr_oe   (ctr_oe),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .bus_in   (bus_in),
        .ctr_q    (ctr_q)
    );

    always #5 clk = ~clk;

    // Shared bus resolution and a simple loadable up-counter.
    assign bus_in = bus_oe ? bus_out : (ctr_oe ? model_q : 8'h00);
    assign ctr_q  = model_q;

    always @(posedge clk) begin
        if (ctr_load)    model_q <= bus_in;
        else if (ctr_en) model_q <= model_q + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ownership invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ctr_en) en_cnt++;
            chk("no_co_drive", {31'd0, bus_oe & ctr_oe}, 32'd0);
            chk("load_en_excl", {31'd0, ctr_load & ctr_en}, 32'd0);
            chk("load_needs_bus", {31'd0, ctr_load & ~bus_oe}, 32'd0);
            chk("turnaround", {31'd0, (bus_oe & prev_ctr_oe) | (ctr_oe & prev_bus_oe)}, 32'd0);
        end
        prev_bus_oe = bus_oe;
        prev_ctr_oe = ctr_oe;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one command and wait for rsp_valid; lat = cycles from acceptance.
    task automatic do_cmd(input logic [1:0] op, input logic [7:0] d, output int lat);
        chk("cmd_ready_before", {31'd0, link.cmd_ready}, 32'd1);
        link.cmd_valid = 1'b1;
        link.cmd_op    = op;
        link.cmd_data  = d;
        step();
        link.cmd_valid = 1'b0;
        lat = 1;
        while (!link.rsp_valid && lat < 400) begin
            step();
            lat++;
        end
        chk("rsp_timeout", {31'd0, link.rsp_valid}, 32'd1);
    endtask

    task automatic finish_rsp();
        step();
        chk("rsp_dropped", {31'd0, link.rsp_valid}, 32'd0);
        chk("cmd_ready_after", {31'd0, link.cmd_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        int en0;
        link.cmd_valid = 1'b0;
        link.cmd_op    = 2'b00;
        link.cmd_data  = 8'h00;
        link.rsp_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_ctr_en", {31'd0, ctr_en}, 32'd0);
        chk("rst_ctr_load", {31'd0, ctr_load}, 32'd0);
        chk("rst_ctr_oe", {31'd0, ctr_oe}, 32'd0);
        chk("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("rst_bus_out", {24'd0, bus_out}, 32'd0);
        chk("rst_rsp_valid", {31'd0, link.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, link.rsp_err}, 32'd0);
        chk("rst_rsp_data", {24'd0, link.rsp_data}, 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("ready_after_rst", {31'd0, link.cmd_ready}, 32'd1);

        // 1: LOAD 0xA5, cycle by cycle
        link.cmd_valid = 1'b1;
        link.cmd_op    = 2'b00;
        link.cmd_data  = 8'hA5;
        step();
        link.cmd_valid = 1'b0;
        chk("ld_c1_bus_oe", {31'd0, bus_oe}, 32'd1);
        chk("ld_c1_bus_out", {24'd0, bus_out}, 32'hA5);
        chk("ld_c1_load", {31'd0, ctr_load}, 32'd0);
        chk("ld_c1_ready", {31'd0, link.cmd_ready}, 32'd0);
        step();
        chk("ld_c2_bus_oe", {31'd0, bus_oe}, 32'd1);
        chk("ld_c2_load", {31'd0, ctr_load}, 32'd1);
        chk("ld_c2_bus_out", {24'd0, bus_out}, 32'hA5);
        step();
        chk("ld_c3_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("ld_c3_load", {31'd0, ctr_load}, 32'd0);
        chk("ld_c3_bus_out", {24'd0, bus_out}, 32'd0);
        chk("ld_c3_rsp_valid", {31'd0, link.rsp_valid}, 32'd0);
        step();
        chk("ld_c4_rsp_valid", {31'd0, link.rsp_valid}, 32'd1);
        chk("ld_c4_rsp_data", {24'd0, link.rsp_data}, 32'hA5);
        chk("ld_c4_rsp_err", {31'd0, link.rsp_err}, 32'd0);
        finish_rsp();

        // 2: LOAD 0xFE then RUN 3 wraps to 0x01
        do_cmd(2'b00, 8'hFE, lat);
        chk("ld_fe_lat", lat, 32'd4);
        chk("ld_fe_data", {24'd0, link.rsp_data}, 32'hFE);
        finish_rsp();
        en0 = en_cnt;
        do_cmd(2'b01, 8'd3, lat);
        chk("run3_lat", lat, 32'd5);
        chk("run3_en_cycles", en_cnt - en0, 32'd3);
        chk("run3_data", {24'd0, link.rsp_data}, 32'h01);
        chk("run3_err", {31'd0, link.rsp_err}, 32'd0);
        finish_rsp();

        // 3: LOAD 0x10 then RUN 0
        do_cmd(2'b00, 8'h10, lat);
        finish_rsp();
        en0 = en_cnt;
        do_cmd(2'b01, 8'd0, lat);
        chk("run0_lat", lat, 32'd2);
        chk("run0_en_cycles", en_cnt - en0, 32'd0);
        chk("run0_data", {24'd0, link.rsp_data}, 32'h10);
        finish_rsp();

        // 4: READ with counter at 0x3C
        do_cmd(2'b00, 8'h3C, lat);
        finish_rsp();
        link.cmd_valid = 1'b1;
        link.cmd_op    = 2'b10;
        link.cmd_data  = 8'hFF;
        step();
        link.cmd_valid = 1'b0;
        chk("rd_c1_ctr_oe", {31'd0, ctr_oe}, 32'd1);
        chk("rd_c1_bus_oe", {31'd0, bus_oe}, 32'd0);
        step();
        chk("rd_c2_ctr_oe", {31'd0, ctr_oe}, 32'd1);
        chk("rd_c2_bus_oe", {31'd0, bus_oe}, 32'd0);
        chk("rd_c2_rsp_valid", {31'd0, link.rsp_valid}, 32'd0);
        step();
        chk("rd_c3_ctr_oe", {31'd0, ctr_oe}, 32'd0);
        chk("rd_c3_rsp_valid", {31'd0, link.rsp_valid}, 32'd1);
        chk("rd_c3_rsp_data", {24'd0, link.rsp_data}, 32'h3C);
        chk("rd_c3_rsp_err", {31'd0, link.rsp_err}, 32'd0);
        finish_rsp();

        // 5: reserved op with the consumer stalled for 5 cycles
        link.rsp_ready = 1'b0;
        link.cmd_valid = 1'b1;
        link.cmd_op    = 2'b11;
        link.cmd_data  = 8'h77;
        step();
        link.cmd_valid = 1'b0;
        chk("rsv_ctr_sigs", {28'd0, ctr_en, ctr_load, ctr_oe, bus_oe}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("rsv_rsp_valid", {31'd0, link.rsp_valid}, 32'd1);
            chk("rsv_rsp_err", {31'd0, link.rsp_err}, 32'd1);
            chk("rsv_rsp_data", {24'd0, link.rsp_data}, 32'd0);
            chk("rsv_cmd_ready", {31'd0, link.cmd_ready}, 32'd0);
            step();
        end
        chk("rsv_rsp_held", {31'd0, link.rsp_valid}, 32'd1);
        link.rsp_ready = 1'b1;
        finish_rsp();

        // 6: reset in the middle of RUN 200
        do_cmd(2'b00, 8'h00, lat);
        finish_rsp();
        link.cmd_valid = 1'b1;
        link.cmd_op    = 2'b01;
        link.cmd_data  = 8'd200;
        step();
        link.cmd_valid = 1'b0;
        for (int k = 1; k < 50; k++) step();
        chk("run200_en_c50", {31'd0, ctr_en}, 32'd1);
        chk("run200_no_rsp", {31'd0, link.rsp_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ctr_en", {31'd0, ctr_en}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, link.rsp_valid}, 32'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("postrst_ready", {31'd0, link.cmd_ready}, 32'd1);
            chk("postrst_rsp_valid", {31'd0, link.rsp_valid}, 32'd0);
            chk("postrst_ctr_en", {31'd0, ctr_en}, 32'd0);
        end

        // Host usable again after the abort
        do_cmd(2'b00, 8'h5A, lat);
        chk("final_ld_data", {24'd0, link.rsp_data}, 32'h5A);
        finish_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
